// File: rtl/if_fetch_q.sv
// Instruction fetch stage: owns the PC, reads imem, buffers fetched words in a QDEPTH-entry prefetch queue.
// Latency: one edge from fetch to instrD when the queue is empty and decode runs; otherwise the word waits for the pops ahead of it.
// Backpressure: stallD holds the decode register while fetch fills the queue; PC freezes once the queue is full.
module if_fetch_q #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              IMEM_AW  = 6,
    parameter int              QDEPTH   = 4,
    localparam int             PW       = $clog2(QDEPTH),
    localparam int             CW       = PW + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stallD,
    input  logic               redirect,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_rdata,
    output logic [XLEN-1:0]    instrD,
    output logic [XLEN-1:0]    pcplus4D,
    output logic               validD,
    output logic [CW-1:0]      q_count
);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pcplus4;
    } fword_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    fword_t          dec_q, dec_d;
    logic            valid_q, valid_d;
    fword_t          mem_q [QDEPTH];

    fword_t fetch_w;
    logic   q_empty, q_full, pop, fe, bypass, push, q_we;
    logic   unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    always_comb begin
        fetch_w  = '{instr: imem_rdata, pcplus4: pc_q + PC_STEP};
        q_empty  = (cnt_q == '0);
        q_full   = (cnt_q == CW'(QDEPTH));
        pop      = !stallD && !q_empty;
        fe       = !q_full || pop;
        // An empty queue with decode running forwards the fetch word straight to decode.
        bypass   = !stallD && q_empty;
        push     = fe && !bypass;

        pc_d     = pc_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        dec_d    = dec_q;
        valid_d  = valid_q;
        q_we     = 1'b0;

        if (redirect) begin
            pc_d     = {redirect_pc[XLEN-1:2], 2'b00};
            cnt_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            dec_d    = '0;
            valid_d  = 1'b0;
        end else begin
            if (fe) begin
                pc_d = pc_q + PC_STEP;
            end
            if (push) begin
                q_we     = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
            if (!stallD) begin
                dec_d   = pop ? mem_q[rd_ptr_q] : fetch_w;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            dec_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            dec_q    <= dec_d;
            valid_q  <= valid_d;
        end
    end

    // Queue storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (q_we) begin
            mem_q[wr_ptr_q] <= fetch_w;
        end
    end

    assign imem_addr = pc_q[IMEM_AW+1:2];
    assign instrD    = dec_q.instr;
    assign pcplus4D  = dec_q.pcplus4;
    assign validD    = valid_q;
    assign q_count   = cnt_q;

endmodule

// File: tb/tb_if_fetch_q.sv
// Bench for if_fetch_q: queue-based reference model checked every cycle, plus directed literal checks.
module tb_if_fetch_q;

    logic        clk;
    logic        reset;
    logic        stallD;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instrD;
    logic [31:0] pcplus4D;
    logic        validD;
    logic [2:0]  q_count;

    int n_chk  = 0;
    int n_fail = 0;

    if_fetch_q #(
        .XLEN(32), .RESET_PC(32'h0), .IMEM_AW(6), .QDEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .stallD(stallD), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instrD(instrD), .pcplus4D(pcplus4D), .validD(validD), .q_count(q_count)
    );

    assign imem_rdata = 32'h1000_0000 + {26'd0, imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a PC plus a bounded FIFO of {instr, pc+4} words.
    logic [31:0] m_pc;
    logic [63:0] m_q[$];
    logic [31:0] m_instr, m_p4;
    logic        m_valid;
    logic [63:0] m_w;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc    = 32'h0;
            m_q.delete();
            m_instr = 32'h0;
            m_p4    = 32'h0;
            m_valid = 1'b0;
        end else begin
            m_w = {32'h1000_0000 + ((m_pc >> 2) & 32'd63), m_pc + 32'd4};
            if (redirect) begin
                m_pc    = redirect_pc & ~32'd3;
                m_q.delete();
                m_instr = 32'h0;
                m_p4    = 32'h0;
                m_valid = 1'b0;
            end else if (stallD) begin
                if (m_q.size() < 4) begin
                    m_q.push_back(m_w);
                    m_pc = m_pc + 32'd4;
                end
            end else begin
                if (m_q.size() == 0) begin
                    {m_instr, m_p4} = m_w;
                end else begin
                    {m_instr, m_p4} = m_q.pop_front();
                    m_q.push_back(m_w);
                end
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("model_instrD",   instrD,           m_instr);
            chk("model_pcplus4D", pcplus4D,         m_p4);
            chk("model_validD",   {31'd0, validD},  {31'd0, m_valid});
            chk("model_q_count",  {29'd0, q_count}, m_q.size());
            chk("model_imem_addr", {26'd0, imem_addr}, (m_pc >> 2) & 32'd63);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; stallD = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        #1 reset = 1'b1;
        #2;
        chk("rst_instrD",   instrD,             32'h0);
        chk("rst_pcplus4D", pcplus4D,           32'h0);
        chk("rst_validD",   {31'd0, validD},    32'h0);
        chk("rst_q_count",  {29'd0, q_count},   32'h0);
        chk("rst_imem_addr", {26'd0, imem_addr}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Streaming with no stall: one instruction per edge, queue stays empty.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("run_instrD",   instrD,           32'h1000_0000 + i);
            chk("run_pcplus4D", pcplus4D,         32'd4 * (i + 1));
            chk("run_validD",   {31'd0, validD},  32'd1);
            chk("run_q_count",  {29'd0, q_count}, 32'd0);
        end

        // Stall fills the queue, then release drains it in order.
        do_reset();
        @(negedge clk);
        chk("stall_first", instrD, 32'h1000_0000);
        stallD = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stall_instrD",  instrD,           32'h1000_0000);
            chk("stall_q_count", {29'd0, q_count}, (i < 4) ? i + 1 : 4);
        end
        chk("stall_imem_addr", {26'd0, imem_addr}, 32'd5);
        stallD = 1'b0;
        @(negedge clk);
        chk("full_pp_q_count", {29'd0, q_count},   32'd4);
        chk("full_pp_addr",    {26'd0, imem_addr}, 32'd6);
        chk("drain_instrD",    instrD,             32'h1000_0001);
        for (int i = 2; i < 6; i++) begin
            @(negedge clk);
            chk("drain_instrD", instrD,          32'h1000_0000 + i);
            chk("drain_validD", {31'd0, validD}, 32'd1);
        end

        // Redirect while stalled with three queued words.
        do_reset();
        stallD = 1'b1;
        repeat (3) @(negedge clk);
        chk("redir_pre_q_count", {29'd0, q_count}, 32'd3);
        redirect = 1'b1; redirect_pc = 32'h23;
        @(negedge clk);
        chk("redir_instrD",   instrD,             32'h0);
        chk("redir_validD",   {31'd0, validD},    32'h0);
        chk("redir_q_count",  {29'd0, q_count},   32'h0);
        chk("redir_imem_addr", {26'd0, imem_addr}, 32'd8);
        redirect = 1'b0; stallD = 1'b0;
        @(negedge clk);
        chk("redir_tgt_instrD",   instrD,          32'h1000_0008);
        chk("redir_tgt_pcplus4D", pcplus4D,        32'h24);
        chk("redir_tgt_validD",   {31'd0, validD}, 32'd1);

        // Asynchronous reset between edges with two queued words.
        do_reset();
        stallD = 1'b0;
        @(negedge clk);
        stallD = 1'b1;
        repeat (2) @(negedge clk);
        chk("arst_pre_q_count", {29'd0, q_count}, 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("arst_instrD",   instrD,           32'h0);
        chk("arst_pcplus4D", pcplus4D,         32'h0);
        chk("arst_validD",   {31'd0, validD},  32'h0);
        chk("arst_q_count",  {29'd0, q_count}, 32'h0);
        @(negedge clk);
        reset = 1'b0; stallD = 1'b0;
        @(negedge clk);
        chk("arst_after_instrD", instrD,          32'h1000_0000);
        chk("arst_after_validD", {31'd0, validD}, 32'd1);

        // imem address wrap at the top of the 64-word space.
        redirect = 1'b1; redirect_pc = 32'hF8;
        @(negedge clk);
        redirect = 1'b0;
        chk("wrap_bubble", {31'd0, validD},    32'd0);
        chk("wrap_addr62", {26'd0, imem_addr}, 32'd62);
        @(negedge clk);
        chk("wrap_instr62", instrD,             32'h1000_003E);
        chk("wrap_addr63",  {26'd0, imem_addr}, 32'd63);
        @(negedge clk);
        chk("wrap_instr63", instrD,             32'h1000_003F);
        chk("wrap_p4_100",  pcplus4D,           32'h100);
        chk("wrap_addr0",   {26'd0, imem_addr}, 32'd0);
        @(negedge clk);
        chk("wrap_instr0", instrD,   32'h1000_0000);
        chk("wrap_p4_104", pcplus4D, 32'h104);

        // Mixed stall/redirect traffic, checked by the model each cycle.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            stallD      = ($urandom_range(0, 2) != 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom;
        end
        @(negedge clk);
        stallD = 1'b0; redirect = 1'b0;
        repeat (6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
